// File: rtl/rv_lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
// No logic: funct3 encodings, FSM state enum and the byte-strobe width.
// Imported by the interface, the load aligner and the LSU top.
package rv_pkg;

    localparam int STRB_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/rv_lsu_if.sv
// Data-bus bundle between the LSU (master) and memory (slave).
// Request channel is valid/ready; the read response is a single-cycle valid.
// The slave holds off a request by keeping BusReady low.
interface rv_lsu_if;
    import rv_pkg::*;

    logic              BusValid;
    logic              BusReady;
    logic              BusWrite;
    logic [31:0]       BusAddr;
    logic [STRB_W-1:0] BusWStrb;
    logic [31:0]       BusWData;
    logic              BusRValid;
    logic [31:0]       BusRData;

    modport master (
        output BusValid, BusWrite, BusAddr, BusWStrb, BusWData,
        input  BusReady, BusRValid, BusRData
    );

    modport slave (
        input  BusValid, BusWrite, BusAddr, BusWStrb, BusWData,
        output BusReady, BusRValid, BusRData
    );

endinterface

// File: rtl/rv_lsu_load_align.sv
// Load formatter: picks the byte/half lane addressed by A[1:0] and extends it.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module lsu_load_align
    import rv_pkg::*;
(
    input  logic [31:0] bus_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by funct3.
    always_comb begin
        byte_sh = bus_rdata_i >> {addr_lo_i, 3'b000};
        half_sh = bus_rdata_i >> {addr_lo_i[1], 4'b0000};
        data_o  = bus_rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   data_o = {24'd0, byte_sh[7:0]};
            F3_H:    data_o = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   data_o = {16'd0, half_sh[15:0]};
            default: data_o = bus_rdata_i;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Memory-stage LSU: one pipeline load/store -> one valid/ready bus transaction (macro RV_LSU_MISALIGN_TRAP_EN traps misaligned H/W).
// Latency: store >= 3 cycles (IDLE,REQ,DONE), load >= 4 (adds WAIT); illegal op 2 cycles; TIMEOUT bounds REQ+WAIT.
// Backpressure: BusReady low holds REQ with stable fields; StallM holds the pipeline until the DoneM pulse.
module rv_lsu
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  StrobeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic [31:0] ReadDataM,
    output logic        FaultM,
    rv_lsu_if.master    bus
);

    // A zero TIMEOUT disables the check, but the counter still needs one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        alo_q, alo_d;
    logic [2:0]        f3_q, f3_d;

    logic              legal;
    logic [STRB_W-1:0] strb_new;
    logic [31:0]       wdata_new;
    logic [31:0]       load_fmt;
    int                cnt_inc;
    logic              timeout_hit;

    // Decide whether the incoming op may reach the bus.
    always_comb begin
        legal = 1'b0;
        if (MemWriteM) begin
            legal = (StrobeM == F3_B) || (StrobeM == F3_H) || (StrobeM == F3_W);
        end else begin
            legal = (StrobeM == F3_B) || (StrobeM == F3_H) || (StrobeM == F3_W) ||
                    (StrobeM == F3_BU) || (StrobeM == F3_HU);
        end
`ifdef RV_LSU_MISALIGN_TRAP_EN
        if ((StrobeM[1:0] == 2'b01) && AddrM[0]) begin
            legal = 1'b0;
        end
        if ((StrobeM[1:0] == 2'b10) && (AddrM[1:0] != 2'b00)) begin
            legal = 1'b0;
        end
`endif
    end

    // Byte enables and lane-replicated write data from access size and address.
    always_comb begin
        strb_new  = 4'b1111;
        wdata_new = WDataM;
        case (StrobeM[1:0])
            2'b00: begin
                strb_new  = 4'b0001 << AddrM[1:0];
                wdata_new = {4{WDataM[7:0]}};
            end
            2'b01: begin
                strb_new  = 4'b0011 << {AddrM[1], 1'b0};
                wdata_new = {2{WDataM[15:0]}};
            end
            default: begin
                strb_new  = 4'b1111;
                wdata_new = WDataM;
            end
        endcase
    end

    lsu_load_align u_align (
        .bus_rdata_i (bus.BusRData),
        .addr_lo_i   (alo_q),
        .funct3_i    (f3_q),
        .data_o      (load_fmt)
    );

    // Next state; in REQ an accepted handshake beats the timeout so the slave never loses an accepted request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        addr_d      = addr_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        alo_d       = alo_q;
        f3_d        = f3_q;
        cnt_inc     = int'(cnt_q) + 1;
        timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TIMEOUT);
        case (state_q)
            IDLE: begin
                if (MemReqM) begin
                    if (legal) begin
                        state_d = REQ;
                        cnt_d   = '0;
                        write_d = MemWriteM;
                        addr_d  = {AddrM[31:2], 2'b00};
                        strb_d  = strb_new;
                        wdata_d = wdata_new;
                        alo_d   = AddrM[1:0];
                        f3_d    = StrobeM;
                    end else begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = CNT_W'(cnt_inc);
                if (bus.BusReady) begin
                    state_d = write_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            WAIT: begin
                cnt_d = CNT_W'(cnt_inc);
                if (bus.BusRValid) begin
                    state_d = DONE;
                    rdata_d = load_fmt;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bus-field registers; reset returns everything to an idle, quiet bus.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            alo_q   <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            alo_q   <= alo_d;
            f3_q    <= f3_d;
        end
    end

    // BusValid follows the REQ state directly, so an async reset drops it at once.
    assign bus.BusValid = (state_q == REQ);
    assign bus.BusWrite = write_q;
    assign bus.BusAddr  = addr_q;
    assign bus.BusWStrb = strb_q;
    assign bus.BusWData = wdata_q;

    assign DoneM     = (state_q == DONE);
    assign FaultM    = fault_q;
    assign ReadDataM = rdata_q;
    assign StallM    = MemReqM & ~DoneM;

endmodule
